// File: rtl/myriadrf_cfg_pkg.sv
// myriadrf_cfg_pkg: shared types, constants and helpers for the MyriadRF config register bank
package myriadrf_cfg_pkg;
   typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR = 3'b010;
   localparam logic [2:0] CTI_END = 3'b111;
   localparam int IDX_W = 8;
   function automatic logic [7:0] byte_merge(input logic [7:0] old_b, input logic [7:0] new_b, input logic sel);
      return sel ? new_b : old_b;
   endfunction
endpackage

// File: rtl/myriadrf_evt_reg.sv
// myriadrf_evt_reg: sticky write-1-to-clear event register with byte-writable mask and registered irq
module myriadrf_evt_reg
   import myriadrf_cfg_pkg::*;
#(
   parameter int WB_DW = 32
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_ni,
   input  logic [WB_DW-1:0]   evt_set,
   input  logic [WB_DW-1:0]   wdat,
   input  logic [WB_DW/8-1:0] sel,
   input  logic               clr_en,
   input  logic               mask_en,
   output logic [WB_DW-1:0]   evt,
   output logic [WB_DW-1:0]   mask,
   output logic               irq
);
   logic [WB_DW-1:0] clr, mask_d;
   always_comb begin
      clr = '0;
      mask_d = mask;
      for (int b = 0; b < WB_DW/8; b++) begin
         clr[b*8 +: 8] = clr_en ? byte_merge(8'h00, wdat[b*8 +: 8], sel[b]) : 8'h00;
         mask_d[b*8 +: 8] = mask_en ? byte_merge(mask[b*8 +: 8], wdat[b*8 +: 8], sel[b]) : mask[b*8 +: 8];
      end
   end
   // a set pulse wins over a simultaneous clear of the same bit
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni) begin
         evt <= '0;
         mask <= '0;
         irq <= 1'b0;
      end else begin
         evt <= (evt & ~clr) | evt_set;
         mask <= mask_d;
         irq <= |(evt & mask);
      end
endmodule

// File: rtl/myriadrf_cfg_regs.sv
// myriadrf_cfg_regs: Wishbone B4 control/status/event register bank with registered-feedback linear bursts
module myriadrf_cfg_regs
   import myriadrf_cfg_pkg::*;
#(
   parameter int WB_AW = 32,
   parameter int WB_DW = 32,
   parameter int NUM_CTRL = 8,
   parameter int NUM_STAT = 4,
   parameter int ADDR_LSB = 2,
   parameter logic [NUM_CTRL*WB_DW-1:0] CTRL_RST = '0
) (
   input  logic                                         wb_clk_i,
   input  logic                                         wb_rst_ni,
   input  logic [WB_AW-1:0]                             wb_adr_i,
   input  logic [WB_DW-1:0]                             wb_dat_i,
   input  logic [WB_DW/8-1:0]                           wb_sel_i,
   input  logic                                         wb_we_i,
   input  logic                                         wb_cyc_i,
   input  logic                                         wb_stb_i,
   input  logic [2:0]                                   wb_cti_i,
   input  logic [1:0]                                   wb_bte_i,
   output logic [WB_DW-1:0]                             wb_dat_o,
   output logic                                         wb_ack_o,
   output logic                                         wb_err_o,
   output logic                                         wb_rty_o,
   output logic [NUM_CTRL*WB_DW-1:0]                    ctrl_o,
   output logic [NUM_CTRL-1:0]                          ctrl_wr_o,
   input  logic [(NUM_STAT > 0 ? NUM_STAT : 1)*WB_DW-1:0] stat_i,
   input  logic [WB_DW-1:0]                             evt_i,
   output logic                                         irq_o
);
   localparam logic [IDX_W-1:0] STAT_IDX = IDX_W'(NUM_CTRL);
   localparam logic [IDX_W-1:0] EVT_IDX = IDX_W'(NUM_CTRL + NUM_STAT);
   localparam logic [IDX_W-1:0] MASK_IDX = EVT_IDX + 1'b1;
   state_t state_q, state_d;
   logic [IDX_W-1:0] idx, idx_q, rd_idx;
   logic [WB_DW-1:0] rd_dat, dat_q, evt, mask;
   logic [NUM_CTRL-1:0][WB_DW-1:0] ctrl_q;
   logic [NUM_CTRL-1:0] ctrl_wr_q;
   logic req, load, rd_ok, commit, ack_q, err_q, unused_ok;
   assign idx = wb_adr_i[ADDR_LSB +: IDX_W];
   assign req = wb_cyc_i & wb_stb_i;
   // in a burst the next beat's data is fetched one index ahead
   assign rd_idx = state_q == IDLE ? idx : idx_q + 1'b1;
   assign rd_ok = rd_idx <= MASK_IDX && !(wb_we_i && rd_idx >= STAT_IDX && rd_idx < EVT_IDX);
   assign commit = ack_q & req & wb_we_i;
   assign unused_ok = ^{wb_adr_i, wb_bte_i, stat_i, wb_cti_i == CTI_CLASSIC};
   always_comb begin
      rd_dat = '0;
      for (int k = 0; k < NUM_CTRL; k++)
         if (rd_idx == IDX_W'(k)) rd_dat = ctrl_q[k];
      for (int k = 0; k < NUM_STAT; k++)
         if (rd_idx == IDX_W'(NUM_CTRL + k)) rd_dat = stat_i[k*WB_DW +: WB_DW];
      if (rd_idx == EVT_IDX) rd_dat = evt;
      if (rd_idx == MASK_IDX) rd_dat = mask;
   end
   always_comb begin
      state_d = state_q;
      load = 1'b0;
      case (state_q)
         IDLE: if (req) begin
            load = 1'b1;
            state_d = wb_cti_i == CTI_INCR ? BURST : CLASSIC;
         end
         CLASSIC: state_d = IDLE;
         BURST: if (!req || wb_cti_i == CTI_END) state_d = IDLE;
                else load = 1'b1;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         idx_q <= '0;
         dat_q <= '0;
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q <= load & rd_ok;
         err_q <= load & ~rd_ok;
         if (load) begin
            idx_q <= rd_idx;
            dat_q <= rd_dat;
         end
      end
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni) begin
         ctrl_q <= CTRL_RST;
         ctrl_wr_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CTRL; i++) begin
            ctrl_wr_q[i] <= commit && idx_q == IDX_W'(i);
            if (commit && idx_q == IDX_W'(i))
               for (int b = 0; b < WB_DW/8; b++)
                  ctrl_q[i][b*8 +: 8] <= byte_merge(ctrl_q[i][b*8 +: 8], wb_dat_i[b*8 +: 8], wb_sel_i[b]);
         end
      end
   myriadrf_evt_reg #(.WB_DW(WB_DW)) u_evt (
      .wb_clk_i (wb_clk_i),
      .wb_rst_ni(wb_rst_ni),
      .evt_set  (evt_i),
      .wdat     (wb_dat_i),
      .sel      (wb_sel_i),
      .clr_en   (commit && idx_q == EVT_IDX),
      .mask_en  (commit && idx_q == MASK_IDX),
      .evt      (evt),
      .mask     (mask),
      .irq      (irq_o)
   );
   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_rty_o = 1'b0;
   assign ctrl_o = ctrl_q;
   assign ctrl_wr_o = ctrl_wr_q;
endmodule

// File: tb/tb_myriadrf_cfg_regs.sv
// tb_myriadrf_cfg_regs: directed Wishbone stimulus with a response scoreboard for myriadrf_cfg_regs
module tb_myriadrf_cfg_regs;
   localparam logic [255:0] RST = {192'h0, 32'h0000_00A5, 32'h0};
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] adr = '0, wdat = '0, rdat, evt_in = '0;
   logic [3:0] sel = '0;
   logic we = 1'b0, cyc = 1'b0, stb = 1'b0, ack, err, rty, irq;
   logic [2:0] cti = '0;
   logic [255:0] ctrl;
   logic [7:0] ctrl_wr;
   logic [127:0] stat = {32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000};
   logic [33:0] exp_q[$];
   int n_tests = 0, n_fail = 0, cyc_n = 0;
   int wr_cnt[8], wr_cyc[8];
   logic [31:0] wr_val[8];

   myriadrf_cfg_regs #(.CTRL_RST(RST)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
      .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(2'b00),
      .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .ctrl_o(ctrl),
      .ctrl_wr_o(ctrl_wr), .stat_i(stat), .evt_i(evt_in), .irq_o(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int wr_total();
      int t = 0;
      for (int i = 0; i < 8; i++) t += wr_cnt[i];
      return t;
   endfunction

   always @(negedge clk)
      if (rst_n && (ack || err)) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_resp: got ack=%b err=%b dat=%h with nothing expected", ack, err, rdat);
         end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            if ({ack, err, rdat} !== e) begin
               n_fail++;
               $display("FAIL resp: got ack=%b err=%b dat=%h expected ack=%b err=%b dat=%h",
                        ack, err, rdat, e[33], e[32], e[31:0]);
            end
         end
      end

   always @(negedge clk) begin
      cyc_n++;
      for (int i = 0; i < 8; i++)
         if (ctrl_wr[i]) begin
            wr_cnt[i]++;
            wr_cyc[i] = cyc_n;
            wr_val[i] = ctrl[i*32 +: 32];
         end
   end

   task automatic wb_classic(input logic w, input logic [7:0] idx, input logic [31:0] d, input logic [3:0] s,
                             input logic ok, input logic [31:0] exp, input logic [31:0] pulse = 0,
                             input logic [21:0] hi = 0);
      int lat = 0;
      exp_q.push_back({ok, !ok, exp});
      adr = {hi, idx, 2'b00}; wdat = d; sel = s; we = w; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
      do begin @(posedge clk); #1; lat++; end while (!(ack || err) && lat < 10);
      check("classic_lat", lat, 1);
      evt_in = pulse;
      @(posedge clk); #1;
      evt_in = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      check("classic_gap", {31'h0, ack | err}, 0);
   endtask

   task automatic wb_burst(input logic w, input logic [7:0] idx, input int n, input logic [31:0] base);
      int t = 0;
      adr = {22'h0, idx, 2'b00}; wdat = base; sel = 4'hF; we = w; cti = 3'b010; cyc = 1'b1; stb = 1'b1;
      do begin @(posedge clk); #1; t++; end while (!(ack || err) && t < 10);
      check("burst_lat", t, 1);
      for (int k = 0; k < n; k++) begin
         check("burst_resp_held", {31'h0, ack | err}, 1);
         @(posedge clk); #1;
         if (k < n - 1) begin
            adr = {22'h0, idx + 8'(k + 1), 2'b00};
            wdat = base + 32'(k + 1);
            cti = (k + 1 == n - 1) ? 3'b111 : 3'b010;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
      check("burst_end", {31'h0, ack | err}, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_ack", {30'h0, ack, err}, 0);
      check("rst_dat", rdat, 0);
      check("rst_irq", {31'h0, irq}, 0);
      check("rst_ctrl_wr", {24'h0, ctrl_wr}, 0);
      check("rst_ctrl0", ctrl[31:0], 0);
      check("rst_ctrl1", ctrl[63:32], 32'hA5);
      wb_classic(1'b0, 8'd1, 0, 4'h0, 1'b1, 32'hA5);
      wb_classic(1'b0, 8'd1, 0, 4'h0, 1'b1, 32'hA5, 0, 22'h2AAAAA);
      wb_classic(1'b1, 8'd0, 32'h1234_5678, 4'b0101, 1'b1, 0);
      repeat (2) @(posedge clk); #1;
      check("wr0_cnt", wr_cnt[0], 1);
      check("wr0_val", wr_val[0], 32'h0034_0078);
      check("ctrl0", ctrl[31:0], 32'h0034_0078);
      wb_classic(1'b1, 8'd6, 32'hFFFF_FFFF, 4'h0, 1'b1, 0);
      repeat (2) @(posedge clk); #1;
      check("wr6_sel0_cnt", wr_cnt[6], 1);
      check("ctrl6_sel0", ctrl[223:192], 0);
      for (int k = 0; k < 4; k++) exp_q.push_back({2'b10, 32'h0});
      wb_burst(1'b1, 8'd2, 4, 32'hC0DE_0000);
      repeat (2) @(posedge clk); #1;
      for (int k = 2; k < 6; k++) begin
         check("burst_ctrl", ctrl[k*32 +: 32], 32'hC0DE_0000 + 32'(k - 2));
         check("burst_wr_cnt", wr_cnt[k], 1);
      end
      for (int k = 3; k < 6; k++) check("burst_wr_consec", wr_cyc[k] - wr_cyc[k-1], 1);
      wb_classic(1'b0, 8'd5, 0, 4'h0, 1'b1, 32'hC0DE_0003);
      wb_classic(1'b1, 8'd9, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h5000_0001);
      wb_classic(1'b1, 8'd200, 32'hDEAD_BEEF, 4'hF, 1'b0, 0);
      repeat (2) @(posedge clk); #1;
      check("err_no_write", wr_total(), 6);
      check("err_ctrl1", ctrl[63:32], 32'hA5);
      wb_classic(1'b0, 8'd10, 0, 4'h0, 1'b1, 32'h5000_0002);
      wb_classic(1'b1, 8'd13, 32'h0000_0008, 4'hF, 1'b1, 0);
      check("irq_masked_idle", {31'h0, irq}, 0);
      evt_in = 32'h8;
      @(posedge clk); #1;
      evt_in = '0;
      check("irq_evt_edge", {31'h0, irq}, 0);
      @(posedge clk); #1;
      check("irq_set", {31'h0, irq}, 1);
      wb_classic(1'b1, 8'd12, 32'h8, 4'hF, 1'b1, 32'h8, 32'h8);
      wb_classic(1'b0, 8'd12, 0, 4'h0, 1'b1, 32'h8);
      check("irq_set_wins", {31'h0, irq}, 1);
      wb_classic(1'b1, 8'd12, 32'h8, 4'hF, 1'b1, 32'h8);
      @(posedge clk); #1;
      check("irq_cleared", {31'h0, irq}, 0);
      wb_classic(1'b0, 8'd12, 0, 4'h0, 1'b1, 0);
      exp_q.push_back({2'b10, 32'h8});
      exp_q.push_back({2'b01, 32'h0});
      exp_q.push_back({2'b01, 32'h0});
      wb_burst(1'b0, 8'd13, 3, 0);
      repeat (2) @(posedge clk); #1;
      check("burst_rd_no_write", wr_total(), 6);
      wb_classic(1'b0, 8'd13, 0, 4'h0, 1'b1, 32'h8);
      repeat (3) @(posedge clk); #1;
      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
